// File: rtl/monkey_pkg.sv
// Shared types for the monkey sprite sequencer: FSM states, bitmap frame codes,
// screen coordinate width and the state-to-bitmap mapping.
package monkey_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    BEAT_L,
    BEAT_R,
    GRAB,
    THROW
  } monkey_state_t;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_BEAT_L,
    FR_BEAT_R,
    FR_THROW
  } monkey_frame_t;

  // GRAB reuses the idle bitmap; only the throw pose has its own art.
  function automatic monkey_frame_t frame_for(monkey_state_t s);
    case (s)
      BEAT_L:  frame_for = FR_BEAT_L;
      BEAT_R:  frame_for = FR_BEAT_R;
      THROW:   frame_for = FR_THROW;
      default: frame_for = FR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// 8-bit video-frame counter: counts startOfFrame pulses, saturates at 255, and
// flags expiry when a pulse arrives while the count sits at limit-1.
module frame_tick_counter (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic [7:0] count,
  output logic       expired
);

  assign expired = tick && (count == (limit - 8'd1));

  // Clear wins over tick so a state change always starts the next state at 0.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (tick && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/monkey_anim_controller.sv
// Per-video-frame monkey animation sequencer: IDLE -> chest beats -> GRAB -> THROW,
// driving the bitmap select, sprite position and the barrel-throw request.
module monkey_anim_controller
  import monkey_pkg::*;
#(
  parameter int IDLE_FRAMES  = 60,
  parameter int BEAT_FRAMES  = 8,
  parameter int BEAT_REPEATS = 3,
  parameter int GRAB_FRAMES  = 16,
  parameter int THROW_FRAMES = 12,
  parameter int HOME_X       = 64,
  parameter int HOME_Y       = 32,
  parameter int HOP_PX       = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 enable,
  input  logic                 throwAck,
  output logic [1:0]           frameSel,
  output logic [COORD_W-1:0]   topLeftX,
  output logic [COORD_W-1:0]   topLeftY,
  output logic                 throwReq,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  // Handshake: throwReq is a level request raised on entry to THROW and held until
  // throwAck is sampled high on any clk edge; the transfer happens on that edge.
  // Acks outside THROW, or after the first one, are ignored.

  monkey_state_t state_q, state_d;
  logic [3:0]    beat_q, beat_d;
  logic          req_q, req_d;
  logic          ack_seen_q, ack_seen_d;
  logic [7:0]    limit;
  logic [7:0]    cnt;
  logic          expired;
  logic          cnt_clear;

  frame_tick_counter u_frame_cnt (
    .clk     (clk),
    .resetN  (resetN),
    .clear   (cnt_clear),
    .tick    (startOfFrame),
    .limit   (limit),
    .count   (cnt),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    req_d      = req_q;
    ack_seen_d = ack_seen_q;
    case (state_q)
      BEAT_L, BEAT_R: limit = 8'(BEAT_FRAMES);
      GRAB:           limit = 8'(GRAB_FRAMES);
      THROW:          limit = 8'(THROW_FRAMES);
      default:        limit = 8'(IDLE_FRAMES);
    endcase

    if (!enable) begin
      state_d    = IDLE;
      beat_d     = 4'd0;
      req_d      = 1'b0;
      ack_seen_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:   if (expired) state_d = BEAT_L;
        BEAT_L: if (expired) state_d = BEAT_R;
        BEAT_R: begin
          if (expired) begin
            if (beat_q == 4'(BEAT_REPEATS - 1)) begin
              state_d = GRAB;
              beat_d  = 4'd0;
            end else begin
              state_d = BEAT_L;
              beat_d  = beat_q + 4'd1;
            end
          end
        end
        GRAB: begin
          if (expired) begin
            state_d    = THROW;
            req_d      = 1'b1;
            ack_seen_d = 1'b0;
          end
        end
        THROW: begin
          if (throwAck && !ack_seen_q) begin
            req_d      = 1'b0;
            ack_seen_d = 1'b1;
          end
          // An ack arriving on the same clk as the exit pulse still counts.
          if (startOfFrame && (cnt >= 8'(THROW_FRAMES - 1)) && (ack_seen_q || throwAck)) begin
            state_d    = IDLE;
            req_d      = 1'b0;
            ack_seen_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    cnt_clear = !enable || (state_d != state_q);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      beat_q     <= 4'd0;
      req_q      <= 1'b0;
      ack_seen_q <= 1'b0;
      frameSel   <= FR_IDLE;
      topLeftY   <= COORD_W'(HOME_Y);
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      req_q      <= req_d;
      ack_seen_q <= ack_seen_d;
      frameSel   <= frame_for(state_d);
      topLeftY   <= ((state_d == BEAT_L) || (state_d == BEAT_R)) ?
                    COORD_W'(HOME_Y - HOP_PX) : COORD_W'(HOME_Y);
      busy       <= (state_d != IDLE);
    end
  end

  assign topLeftX  = COORD_W'(HOME_X);
  assign throwReq  = req_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_monkey_anim_controller.sv
// Directed, table-driven bench for monkey_anim_controller with small frame limits;
// one startOfFrame pulse every 10 clocks.
module tb_monkey_anim_controller;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        enable;
  logic        throwAck;
  logic [1:0]  frameSel;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        throwReq;
  logic        busy;
  logic [2:0]  state_dbg;

  monkey_anim_controller #(
    .IDLE_FRAMES  (4),
    .BEAT_FRAMES  (2),
    .BEAT_REPEATS (2),
    .GRAB_FRAMES  (3),
    .THROW_FRAMES (2),
    .HOME_X       (64),
    .HOME_Y       (32),
    .HOP_PX       (2)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .throwAck     (throwAck),
    .frameSel     (frameSel),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .throwReq     (throwReq),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [10:0] y;
    logic        busy;
    logic        req;
  } vec_t;

  vec_t        tbl[17];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          hi_cnt   = 0;
  int          rise_cnt = 0;
  logic        req_prev = 1'b0;

  always @(negedge clk) begin
    if (throwReq) hi_cnt++;
    if (throwReq && !req_prev) rise_cnt++;
    req_prev = throwReq;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic ack_pulse();
    throwAck = 1'b1;
    step();
    throwAck = 1'b0;
  endtask

  task automatic do_reset();
    resetN       = 1'b0;
    enable       = 1'b0;
    throwAck     = 1'b0;
    startOfFrame = 1'b0;
    gap(2);
    resetN = 1'b1;
    step();
  endtask

  task automatic set_row(input int i, input logic [1:0] sel, input logic [10:0] y,
                         input logic b, input logic r);
    tbl[i].en   = 1'b1;
    tbl[i].sel  = sel;
    tbl[i].y    = y;
    tbl[i].busy = b;
    tbl[i].req  = r;
  endtask

  task automatic check_row(input int i);
    check($sformatf("row%0d_sel", i), 32'(frameSel), 32'(tbl[i].sel));
    check($sformatf("row%0d_y", i), 32'(topLeftY), 32'(tbl[i].y));
    check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    check($sformatf("row%0d_req", i), 32'(throwReq), 32'(tbl[i].req));
  endtask

  // Runs from reset through the GRAB->THROW transition with throwAck low; optionally
  // pokes throwAck in every gap before THROW, which must have no effect.
  task automatic run_to_throw(input bit ack_noise);
    for (int i = 0; i < 15; i++) begin
      enable = tbl[i].en;
      frame_pulse();
      check_row(i);
      if (ack_noise && i < 14) begin
        gap(3);
        ack_pulse();
        check($sformatf("noise%0d_req", i), 32'(throwReq), 32'd0);
        check($sformatf("noise%0d_sel", i), 32'(frameSel), 32'(tbl[i].sel));
        gap(5);
      end else begin
        gap(9);
      end
    end
  endtask

  initial begin
    // Expected state after each startOfFrame pulse, counted from reset with enable=1.
    for (int i = 0; i < 3; i++)   set_row(i, 2'd0, 11'd32, 1'b0, 1'b0);
    for (int i = 3; i < 5; i++)   set_row(i, 2'd1, 11'd30, 1'b1, 1'b0);
    for (int i = 5; i < 7; i++)   set_row(i, 2'd2, 11'd30, 1'b1, 1'b0);
    for (int i = 7; i < 9; i++)   set_row(i, 2'd1, 11'd30, 1'b1, 1'b0);
    for (int i = 9; i < 11; i++)  set_row(i, 2'd2, 11'd30, 1'b1, 1'b0);
    for (int i = 11; i < 14; i++) set_row(i, 2'd0, 11'd32, 1'b1, 1'b0);
    set_row(14, 2'd3, 11'd32, 1'b1, 1'b1);
    set_row(15, 2'd3, 11'd32, 1'b1, 1'b0);
    set_row(16, 2'd0, 11'd32, 1'b0, 1'b0);

    // reset values, checked while reset is still asserted
    resetN       = 1'b0;
    enable       = 1'b0;
    throwAck     = 1'b0;
    startOfFrame = 1'b0;
    gap(3);
    check("rst_sel", 32'(frameSel), 32'd0);
    check("rst_x", 32'(topLeftX), 32'd64);
    check("rst_y", 32'(topLeftY), 32'd32);
    check("rst_req", 32'(throwReq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetN = 1'b1;
    step();

    // full sequence with ack tied high
    enable   = 1'b1;
    throwAck = 1'b1;
    hi_cnt   = 0;
    rise_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(32'(tbl[i].sel));
      enable = tbl[i].en;
      frame_pulse();
      check_row(i);
      check($sformatf("row%0d_x", i), 32'(topLeftX), 32'd64);
      check($sformatf("seq%0d_sel", i), 32'(frameSel), exp_q.pop_front());
      gap(9);
    end
    check("tied_ack_req_cycles", 32'(hi_cnt), 32'd1);
    check("tied_ack_req_rises", 32'(rise_cnt), 32'd1);

    // async reset in the middle of BEAT_L
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame_pulse();
      gap(9);
    end
    check("pre_rst_sel", 32'(frameSel), 32'd1);
    resetN = 1'b0;
    step();
    check("midrst_sel", 32'(frameSel), 32'd0);
    check("midrst_y", 32'(topLeftY), 32'd32);
    check("midrst_req", 32'(throwReq), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    resetN = 1'b1;
    step();

    // stray acks before THROW, then ack withheld for 5 frames
    do_reset();
    hi_cnt   = 0;
    rise_cnt = 0;
    run_to_throw(1'b1);
    for (int f = 0; f < 5; f++) begin
      frame_pulse();
      check($sformatf("hold%0d_req", f), 32'(throwReq), 32'd1);
      check($sformatf("hold%0d_sel", f), 32'(frameSel), 32'd3);
      gap(9);
    end
    check("hold_req_rises", 32'(rise_cnt), 32'd1);
    ack_pulse();
    check("late_ack_req", 32'(throwReq), 32'd0);
    check("late_ack_sel", 32'(frameSel), 32'd3);
    gap(8);
    frame_pulse();
    check("late_exit_sel", 32'(frameSel), 32'd0);
    check("late_exit_busy", 32'(busy), 32'd0);
    gap(9);

    // early ack: THROW must still last its minimum two frames
    do_reset();
    run_to_throw(1'b0);
    gap(2);
    ack_pulse();
    check("early_ack_req", 32'(throwReq), 32'd0);
    check("early_ack_sel", 32'(frameSel), 32'd3);
    frame_pulse();
    check("early_f1_sel", 32'(frameSel), 32'd3);
    check("early_f1_req", 32'(throwReq), 32'd0);
    gap(9);
    frame_pulse();
    check("early_f2_sel", 32'(frameSel), 32'd0);
    check("early_f2_busy", 32'(busy), 32'd0);
    gap(9);

    // disable while throwReq pending, then re-enable
    do_reset();
    run_to_throw(1'b0);
    enable = 1'b0;
    step();
    check("dis_req", 32'(throwReq), 32'd0);
    check("dis_sel", 32'(frameSel), 32'd0);
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_y", 32'(topLeftY), 32'd32);
    gap(3);
    frame_pulse();
    check("dis_frame_sel", 32'(frameSel), 32'd0);
    gap(9);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame_pulse();
      check($sformatf("reen%0d_sel", i), 32'(frameSel), 32'd0);
      check($sformatf("reen%0d_busy", i), 32'(busy), 32'd0);
      gap(9);
    end
    frame_pulse();
    check("reen_beat_sel", 32'(frameSel), 32'd1);
    check("reen_beat_y", 32'(topLeftY), 32'd30);
    gap(9);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
